sm2tc_pipe: RTL and testbench
=============================

Name: sm2tc_pipe

Overview:
- Streaming sign-magnitude to two's-complement converter; the inverse of the team's absolute-value datapath.
- Takes an unsigned magnitude plus a separate sign bit and re-applies the sign, producing a two's-complement word.
- Two-stage valid/ready pipeline, with range checking, optional saturation and a sticky overflow counter.
- Sits downstream of magnitude-domain processing to restore signed samples before the signed datapath.

Parameters:
- width, 8, data width of magnitude input and two's-complement output.
- SAT, 1, 1 = saturate out-of-range results; 0 = wrap (low width bits of negated/passed value).
- CNT_W, 16, width of overflow event counter.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts input this cycle.
- in_sign  input  1  1 = negative.
- in_mag  input  width  unsigned magnitude (0..2^width-1).
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  width  two's-complement result.
- out_ovf  output  1  this output word was out of range (qualified by out_valid).
- ovf_count  output  CNT_W  number of accepted out-of-range words; saturates at all-ones.
- ovf_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset, checked on the clk edge with rst=1:
  - both stage valids = 0, out_valid = 0, out_data = 0, out_ovf = 0, ovf_count = 0.
  - in_ready = 1 in the first cycle after reset.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1 (S1) registers sign, magnitude and valid, and computes the range flag:
  - ovf = (sign=0 && mag > 2^(width-1)-1) || (sign=1 && mag > 2^(width-1)).
- Stage 2 (S2) registers the result, ovf and valid. S2 drives out_valid, out_data and out_ovf.
- Result:
  - sign=0 in range: mag.
  - sign=1 in range: (~mag + 1) truncated to width.
  - mag=0 with sign=1 (negative zero): 0, ovf=0.
  - mag=2^(width-1) with sign=1: 100..0, ovf=0.
- Out of range, SAT=1:
  - positive gives 0111..1.
  - negative gives 100..0.
- Out of range, SAT=0: same arithmetic as in range, truncated to width bits; ovf still flagged.
- Flow control:
  - S2 loads when !S2.valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !S1.valid || S2 load condition (combinational from out_ready).
  - S1/S2 valid clear when their contents move on and nothing replaces them.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held 1.
- Throughput: 1 word per cycle.
- Stall:
  - out_valid=1 && out_ready=0 → out_data/out_ovf are held stable.
  - At most 2 words are buffered; in_ready drops once both stages are full.
- No data is lost or duplicated under any valid/ready pattern. out_valid never deasserts without a transfer.
- ovf_count:
  - Increments by 1 when a word with ovf=1 enters S2.
  - Holds at 2^CNT_W-1.
  - ovf_clr=1 forces 0 next cycle and takes priority over a simultaneous increment.
- Reset mid-operation: all buffered words are discarded; the outputs return to reset values on the next edge.

Test Plan (width=8):
- Reset, then in_valid=0 → out_valid=0, out_data=0x00, ovf_count=0, in_ready=1.
- Stream with out_ready=1 → sign=0/mag=0x05 gives 0x05; sign=1/mag=0x05 gives 0xFB; sign=1/mag=0x80 gives 0x80 with ovf=0; sign=1/mag=0x00 gives 0x00. Each appears 2 cycles after acceptance, back-to-back.
- Overflow with SAT=1 → sign=0/mag=0x80 gives 0x7F with ovf=1; sign=1/mag=0xFF gives 0x80 with ovf=1; ovf_count=2.
- Overflow with SAT=0 → sign=0/mag=0x80 gives 0x80 with ovf=1; sign=1/mag=0x81 gives 0x7F with ovf=1.
- Backpressure: push 4 words, out_ready=0 for 5 cycles → in_ready=0 after 2 accepted, out_data stable; release → all 4 words out, in order, once each.
- ovf_clr asserted in the same cycle as an overflow word enters S2 → ovf_count=0. Also: assert rst with 2 words buffered → out_valid=0 next cycle and those words never appear.

Source files
------------

// File: rtl/sm2tc_pipe.sv
// sm2tc_pipe
// Streaming sign-magnitude to two's-complement converter. An unsigned
// magnitude plus a sign bit is turned back into a two's-complement word by
// a two-stage valid/ready pipeline. Out-of-range results are either
// saturated or wrapped, flagged on out_ovf, and counted in ovf_count.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   block accepts an input word this cycle
//   in_sign    1 = negative
//   in_mag     unsigned magnitude
//   out_valid  output word valid
//   out_ready  downstream accepts the output word
//   out_data   two's-complement result
//   out_ovf    this output word was out of range
//   ovf_count  accepted out-of-range words, saturating at all-ones
//   ovf_clr    synchronous clear of ovf_count
module sm2tc_pipe #(
  parameter int width = 8,
  parameter bit SAT   = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [width-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  // Largest positive and most negative representable results.
  localparam logic [width-1:0] max_pos = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] min_neg = {1'b1, {(width-1){1'b0}}};

  logic             s1_valid_reg;
  logic             s1_sign_reg;
  logic             s1_ovf_reg;
  logic [width-1:0] s1_mag_reg;

  logic             s2_valid_reg;
  logic             s2_ovf_reg;
  logic [width-1:0] s2_data_reg;

  logic [CNT_W-1:0] cnt_reg;

  logic             s2_load;
  logic             in_ovf;
  logic [width-1:0] conv_next;

  // S2 can take a new word when it is empty or its word leaves this cycle.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_load;

  // A negative magnitude may reach one step further than a positive one.
  assign in_ovf = in_sign ? (in_mag > min_neg) : (in_mag > max_pos);

  always_comb begin
    conv_next = s1_sign_reg ? (~s1_mag_reg + width'(1)) : s1_mag_reg;
    if (SAT && s1_ovf_reg) begin
      conv_next = s1_sign_reg ? min_neg : max_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_ovf_reg   <= 1'b0;
      s1_mag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_ovf_reg   <= 1'b0;
      s2_data_reg  <= '0;
      cnt_reg      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_sign_reg <= in_sign;
          s1_mag_reg  <= in_mag;
          s1_ovf_reg  <= in_ovf;
        end
      end

      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= conv_next;
          s2_ovf_reg  <= s1_ovf_reg;
        end
      end

      // Clear wins over an increment landing on the same edge.
      if (ovf_clr) begin
        cnt_reg <= '0;
      end else if (s2_load && s1_valid_reg && s1_ovf_reg && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign out_ovf   = s2_ovf_reg;
  assign ovf_count = cnt_reg;

endmodule

// File: tb/tb_sm2tc_pipe.sv
// Testbench for sm2tc_pipe. Two instances share one stimulus: a saturating
// one with a 16-bit counter and a wrapping one with a 3-bit counter so that
// counter saturation is reachable quickly. Accepted words are queued per
// instance and every output transfer is compared against a signed-integer
// reference conversion.
module tb_sm2tc_pipe;

  localparam int W      = 8;
  localparam int HI     = 2 ** (W - 1) - 1;
  localparam int LO     = -(2 ** (W - 1));
  localparam int MASK   = 2 ** W - 1;
  localparam int CMAX_A = 65535;
  localparam int CMAX_B = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sign = 1'b0;
  logic [W-1:0] in_mag = '0;
  logic         out_ready = 1'b0;
  logic         ovf_clr = 1'b0;

  logic         in_ready_a, out_valid_a, out_ovf_a;
  logic [W-1:0] out_data_a;
  logic [15:0]  ovf_count_a;
  logic         in_ready_b, out_valid_b, out_ovf_b;
  logic [W-1:0] out_data_b;
  logic [2:0]   ovf_count_b;

  sm2tc_pipe #(.width(W), .SAT(1'b1), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a),
    .ovf_count(ovf_count_a), .ovf_clr(ovf_clr)
  );

  sm2tc_pipe #(.width(W), .SAT(1'b0), .CNT_W(3)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b),
    .ovf_count(ovf_count_b), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s;
    int mag;
    int cyc;
  } word_t;

  word_t qa[$];
  word_t qb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cnt_a = 0;
  int    cnt_b = 0;
  bit    lat_chk = 0;
  bit    last_acc_a = 0;
  bit    stall_a = 0, stall_b = 0;
  logic [W:0] held_a, held_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the sign in plain integer arithmetic, then range-check.
  function automatic void ref_conv(input bit s, input int mag, input bit sat,
                                   output int data, output bit ovf);
    int v;
    v   = s ? -mag : mag;
    ovf = (v > HI) || (v < LO);
    if (ovf && sat) v = (v > HI) ? HI : LO;
    data = v & MASK;
  endfunction

  function automatic bit is_ovf(input bit s, input int mag);
    int d;
    bit o;
    ref_conv(s, mag, 1'b1, d, o);
    return o;
  endfunction

  // One clock cycle: sample handshakes mid-cycle, update the model, advance.
  task automatic tick();
    word_t e;
    int    d;
    bit    o;
    @(negedge clk);
    last_acc_a = 0;
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a   = 0;
      cnt_b   = 0;
      stall_a = 0;
      stall_b = 0;
    end else begin
      if (stall_a) begin
        chk("a_hold_valid", out_valid_a, 1);
        chk("a_hold_word", {out_ovf_a, out_data_a}, held_a);
      end
      if (stall_b) begin
        chk("b_hold_valid", out_valid_b, 1);
        chk("b_hold_word", {out_ovf_b, out_data_b}, held_b);
      end
      // Everything accepted before a clear tick has reached S2 by its edge.
      if (ovf_clr) begin
        cnt_a = 0;
        cnt_b = 0;
      end
      if (in_valid && in_ready_a) begin
        qa.push_back('{in_sign, int'(in_mag), cyc});
        last_acc_a = 1;
        if (is_ovf(in_sign, int'(in_mag)) && cnt_a < CMAX_A) cnt_a++;
      end
      if (in_valid && in_ready_b) begin
        qb.push_back('{in_sign, int'(in_mag), cyc});
        if (is_ovf(in_sign, int'(in_mag)) && cnt_b < CMAX_B) cnt_b++;
      end
      if (out_valid_a && out_ready) begin
        chk("a_expected_word", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          ref_conv(e.s, e.mag, 1'b1, d, o);
          $display("sat  out: sign=%0d mag=0x%02h -> data=0x%02h ovf=%0d", e.s, e.mag, out_data_a, out_ovf_a);
          chk("a_data", out_data_a, d);
          chk("a_ovf", out_ovf_a, o);
          if (lat_chk) chk("a_latency", cyc - e.cyc, 2);
        end
      end
      if (out_valid_b && out_ready) begin
        chk("b_expected_word", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          ref_conv(e.s, e.mag, 1'b0, d, o);
          $display("wrap out: sign=%0d mag=0x%02h -> data=0x%02h ovf=%0d", e.s, e.mag, out_data_b, out_ovf_b);
          chk("b_data", out_data_b, d);
          chk("b_ovf", out_ovf_b, o);
          if (lat_chk) chk("b_latency", cyc - e.cyc, 2);
        end
      end
      stall_a = out_valid_a && !out_ready;
      stall_b = out_valid_b && !out_ready;
      held_a  = {out_ovf_a, out_data_a};
      held_b  = {out_ovf_b, out_data_b};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input bit s, input logic [W-1:0] mag);
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = mag;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid_a"}, out_valid_a, 0);
    chk({tag, "_out_data_a"}, out_data_a, 0);
    chk({tag, "_out_ovf_a"}, out_ovf_a, 0);
    chk({tag, "_count_a"}, ovf_count_a, 0);
    chk({tag, "_in_ready_a"}, in_ready_a, 1);
    chk({tag, "_out_valid_b"}, out_valid_b, 0);
    chk({tag, "_count_b"}, ovf_count_b, 0);
    chk({tag, "_in_ready_b"}, in_ready_b, 1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_count_a"}, ovf_count_a, cnt_a);
    chk({tag, "_count_b"}, ovf_count_b, cnt_b);
    chk({tag, "_drained_a"}, qa.size(), 0);
    chk({tag, "_drained_b"}, qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    logic [W-1:0] m;

    // Reset, then idle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");
    idle(1);
    check_reset_state("idle");

    // Back-to-back in-range stream with latency checking.
    out_ready = 1'b1;
    lat_chk   = 1;
    send(1'b0, 8'h05);
    send(1'b1, 8'h05);
    send(1'b1, 8'h80);
    send(1'b1, 8'h00);
    send(1'b0, 8'h7F);
    idle(3);
    lat_chk = 0;
    check_counts("stream");

    // Out-of-range words.
    send(1'b0, 8'h80);
    send(1'b1, 8'hFF);
    send(1'b1, 8'h81);
    idle(3);
    check_counts("ovf");
    chk("ovf_count_three", ovf_count_a, 3);

    // Backpressure: 4 words against a stalled output.
    out_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (n < 4) begin
        in_valid = 1'b1;
        in_sign  = n[0];
        in_mag   = 8'h30 + 8'(n);
      end
      tick();
      if (last_acc_a) n++;
      if (n >= 2) chk("bp_in_ready", in_ready_a, 0);
    end
    chk("bp_accepted", n, 2);
    out_ready = 1'b1;
    guard = 0;
    while (n < 4 && guard < 20) begin
      in_valid = 1'b1;
      in_sign  = n[0];
      in_mag   = 8'h30 + 8'(n);
      tick();
      if (last_acc_a) n++;
      guard++;
    end
    chk("bp_all_sent", n, 4);
    idle(4);
    check_counts("bp");

    // Clear on the same edge an overflow word enters S2.
    send(1'b0, 8'h90);
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr = 1'b0;
    idle(3);
    check_counts("clr");
    chk("clr_zero", ovf_count_a, 0);

    // Counter saturation on the narrow counter.
    for (int k = 0; k < 9; k++) send(1'b1, 8'hC0);
    idle(3);
    check_counts("csat");
    chk("csat_b_full", ovf_count_b, 7);

    // Reset with two words buffered; they must never appear.
    out_ready = 1'b0;
    send(1'b0, 8'h11);
    send(1'b1, 8'h22);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    out_ready = 1'b1;
    idle(4);
    check_counts("midrst_after");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 7))
        0: m = 8'h00;
        1: m = 8'h7F;
        2: m = 8'h80;
        3: m = 8'h81;
        4: m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sign   = 1'($urandom);
      in_mag    = m;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check_counts("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
